// File: rtl/gate_unit_arbiter.sv
// rtl/gate_unit_arbiter.sv - round-robin arbiter sharing one registered bitwise logic unit
module gate_unit_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [2*N_REQ-1:0]     op,
    input  logic [WIDTH*N_REQ-1:0] a,
    input  logic [WIDTH*N_REQ-1:0] b,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH-1:0]       result,
    output logic                   busy
);

    localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDXW-1:0]   ptr;
    logic [IDXW-1:0]   win_idx;
    logic [1:0]        lat_op;
    logic [WIDTH-1:0]  lat_a;
    logic [WIDTH-1:0]  lat_b;
    logic [WIDTH-1:0]  alu_out;

    logic [1:0]        op_arr [N_REQ];
    logic [WIDTH-1:0]  a_arr  [N_REQ];
    logic [WIDTH-1:0]  b_arr  [N_REQ];

    logic              pick_vld;
    logic [IDXW-1:0]   pick;
    logic [IDXW-1:0]   cand;
    int                cand_i;

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign op_arr[g] = op[2*g +: 2];
        assign a_arr[g]  = a[WIDTH*g +: WIDTH];
        assign b_arr[g]  = b[WIDTH*g +: WIDTH];
    end

    // Search starts one past the last winner so every requester gets a turn.
    always_comb begin
        pick_vld = 1'b0;
        pick     = '0;
        cand     = '0;
        cand_i   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand_i = (int'(ptr) + k) % N_REQ;
            cand   = IDXW'(cand_i);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick     = cand;
            end
        end
    end

    always_comb begin
        case (lat_op)
            2'b00:   alu_out = lat_a | lat_b;
            2'b01:   alu_out = lat_a & lat_b;
            2'b10:   alu_out = lat_a ^ lat_b;
            default: alu_out = ~(lat_a | lat_b);
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are captured only in IDLE; later input changes cannot disturb an operation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr     <= IDXW'(N_REQ - 1);
            win_idx <= '0;
            lat_op  <= '0;
            lat_a   <= '0;
            lat_b   <= '0;
            result  <= '0;
        end else begin
            if (state == IDLE && pick_vld) begin
                win_idx <= pick;
                lat_op  <= op_arr[pick];
                lat_a   <= a_arr[pick];
                lat_b   <= b_arr[pick];
            end
            if (state == EXEC) begin
                result <= alu_out;
            end
            if (state == RESP) begin
                ptr <= win_idx;
            end
        end
    end

    // Outputs decode registered state only, so there is no path from req.
    always_comb begin
        gnt  = '0;
        done = '0;
        busy = 1'b0;
        case (state)
            EXEC: begin
                gnt[win_idx] = 1'b1;
                busy         = 1'b1;
            end
            RESP: begin
                gnt[win_idx]  = 1'b1;
                done[win_idx] = 1'b1;
                busy          = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_gate_unit_arbiter.sv
// tb/tb_gate_unit_arbiter.sv - directed scoreboard bench for gate_unit_arbiter
module tb_gate_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [7:0]  result;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        int         idx;
        logic [7:0] res;
    } exp_t;
    exp_t sb[$];

    gate_unit_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .a(a), .b(b),
        .gnt(gnt), .done(done), .result(result), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            2'b00:   return x | y;
            2'b01:   return x & y;
            2'b10:   return x ^ y;
            default: return ~(x | y);
        endcase
    endfunction

    task automatic set_req(input int i, input logic [1:0] o, input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        req[i]       = 1'b1;
        op[2*i +: 2] = o;
        a[8*i +: 8]  = x;
        b[8*i +: 8]  = y;
        e.idx = i;
        e.res = model(o, x, y);
        sb.push_back(e);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Advances at least one cycle, then up to a bounded number more, until a done pulse.
    task automatic wait_done(output int at);
        exp_t e;
        int n;
        n = 0;
        tick();
        while (done == 4'b0 && n < 20) begin
            chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            tick();
            n++;
        end
        at = cyc;
        chk("done_timeout", 32'(done != 4'b0), 32'd1);
        if (done != 4'b0) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("done_idx", 32'(done), 32'(4'b1 << e.idx));
                chk("gnt_in_resp", 32'(gnt), 32'(4'b1 << e.idx));
                chk("result", 32'(result), 32'(e.res));
            end
        end
    endtask

    initial begin
        int t1;
        int t2;
        logic [7:0] prev;
        logic [1:0] seq_ops [3];
        seq_ops[0] = 2'b01;
        seq_ops[1] = 2'b10;
        seq_ops[2] = 2'b11;
        op = '0;
        a  = '0;
        b  = '0;

        do_reset();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_result", 32'(result), 32'd0);

        // single request, OR
        set_req(0, 2'b00, 8'hA5, 8'h0F);
        tick();
        chk("c1_gnt", 32'(gnt), 32'h1);
        chk("c1_busy", 32'(busy), 32'd1);
        chk("c1_done", 32'(done), 32'd0);
        wait_done(t1);
        req = '0;
        tick();
        chk("c3_busy", 32'(busy), 32'd0);
        chk("c3_gnt", 32'(gnt), 32'd0);
        chk("c3_result_hold", 32'(result), 32'hAF);
        prev = 8'hAF;

        // requester 1, AND/XOR/NOR in sequence
        for (int k = 0; k < 3; k++) begin
            set_req(1, seq_ops[k], 8'hA5, 8'h0F);
            tick();
            chk("seq_hold_exec", 32'(result), 32'(prev));
            wait_done(t1);
            req = '0;
            prev = model(seq_ops[k], 8'hA5, 8'h0F);
            tick();
            chk("seq_hold_idle", 32'(result), 32'(prev));
        end

        // requesters 0 and 2 together
        do_reset();
        set_req(0, 2'b00, 8'hA5, 8'h0F);
        set_req(2, 2'b01, 8'h3C, 8'hF0);
        wait_done(t1);
        req[0] = 1'b0;
        tick();
        chk("done_width", 32'(done), 32'd0);
        wait_done(t2);
        req[2] = 1'b0;
        chk("done_spacing", 32'(t2 - t1), 32'd3);

        // all four continuously: order 0,1,2,3,0,1
        do_reset();
        for (int r = 0; r < 6; r++) begin
            case (r % 4)
                0: set_req(0, 2'b00, 8'hA5, 8'h0F);
                1: set_req(1, 2'b01, 8'hA5, 8'h0F);
                2: set_req(2, 2'b10, 8'h3C, 8'hF0);
                default: set_req(3, 2'b11, 8'h81, 8'h42);
            endcase
        end
        t1 = 0;
        for (int r = 0; r < 6; r++) begin
            wait_done(t2);
            if (r > 0) chk("rr_spacing", 32'(t2 - t1), 32'd3);
            t1 = t2;
        end
        req = '0;
        tick();

        // operand change during EXEC is ignored
        set_req(0, 2'b00, 8'hA5, 8'h0F);
        tick();
        chk("latch_exec_gnt", 32'(gnt), 32'h1);
        a[7:0] = 8'h00;
        wait_done(t1);
        req = '0;
        tick();

        // reset during EXEC aborts the operation
        req[0] = 1'b1;
        op[1:0] = 2'b10;
        a[7:0] = 8'hFF;
        b[7:0] = 8'h0F;
        tick();
        chk("abort_exec_gnt", 32'(gnt), 32'h1);
        rst_n = 1'b0;
        req = '0;
        tick();
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
        end
        set_req(0, 2'b00, 8'h44, 8'h22);
        set_req(3, 2'b00, 8'h10, 8'h01);
        wait_done(t1);
        req[0] = 1'b0;
        wait_done(t2);
        req[3] = 1'b0;
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
